event_arbiter: RTL and testbench
================================

// Module: event_arbiter
// PURPOSE
// Collects release events (falling edges) from the five debounced inputs (test,
// medicina, energia, ultrasonido, fotocelda) and queues one pending flag per source.
// Grants one event at a time by fixed priority to the pet state machine over a
// valid/ready handshake, then enforces a cooldown before the next grant.
// Sits between the debounce bank and the main FSM, replacing per-input toggle flops.
// PARAMETERS
// COOLDOWN  16  clk cycles held in COOLDOWN after each accepted event (0 = none)
// CNT_W     8   width of drop_count (saturating)
// PORTS
// clk          in   1      system clock, all logic on posedge
// reset        in   1      asynchronous, active-low; clears all state
// test_db      in   1      debounced test button level, clk-synchronous
// medicina_db  in   1      debounced medicina button level
// energia_db   in   1      debounced energia button level
// ult_db       in   1      debounced ultrasonic sensor level
// fot_db       in   1      debounced photocell level
// src_mask     in   5      1 = source ignored; bit0 test .. bit4 fot
// ev_ready     in   1      FSM accepts ev_code this cycle
// ev_valid     out  1      ev_code valid
// ev_code      out  3      0 none,1 test,2 medicina,3 energia,4 ult,5 fot
// pending      out  5      current pending flags (same bit order as src_mask)
// drop_count   out  CNT_W  events lost because source already pending; saturates
// BEHAVIOUR
// - reset low (async): state IDLE, ev_valid=0, ev_code=0, pending=0, drop_count=0,
//   edge registers=0, cooldown counter=0. Held while reset low.
// - Edge detect: prev[i] <= in[i] each cycle; fall[i] = prev[i] & ~in[i] & ~src_mask[i].
//   Edge regs reset to 0, so an input already low after reset never yields a fall.
// - pending[i] <= (pending[i] & ~clr[i]) | fall[i]; visible one cycle after fall.
// - clr[i] = handshake (ev_valid & ev_ready) on source i this cycle.
// - Drop: fall[i] while pending[i]=1 and not clr[i] -> drop_count+1 (sat at 2^CNT_W-1);
//   fall[i] in same cycle as clr[i] re-sets pending[i], no drop.
// - Eligible = pending & ~src_mask. Priority: test > medicina > energia > ult > fot.
// - FSM states:
//   IDLE: ev_valid=0. If eligible!=0 -> OFFER; ev_code latched = highest-priority eligible.
//   OFFER: ev_valid=1, ev_code stable (no re-arbitration even if higher source arrives
//     or the offered source becomes masked). On ev_ready: clear that pending bit;
//     COOLDOWN!=0 -> COOLDOWN with cnt=COOLDOWN-1; COOLDOWN==0 -> IDLE.
//   COOLDOWN: ev_valid=0, ev_code=0; cnt decrements; at cnt==0 -> IDLE.
// - Latency: fall at edge t -> pending at t+1 -> ev_valid at t+2 (IDLE, no cooldown).
// - Back-to-back (COOLDOWN=0): next offer one cycle after handshake (IDLE bubble).
// - ev_code=0 whenever ev_valid=0. ev_ready ignored outside OFFER.
// - Falls continue to latch during OFFER and COOLDOWN.
// - Masking a source does not clear its pending bit; unmasking makes it eligible again.
// - Reset asserted mid-OFFER/COOLDOWN: everything cleared, queued events discarded.
// TESTING
// - Reset: drive reset=0 with all inputs high, release -> ev_valid=0, pending=0,
//   drop_count=0; inputs held low after release -> no event.
// - Single event: energia_db 1->0, ev_ready=1 -> ev_valid high 2 cycles later,
//   ev_code=3 for one cycle, then 16 cycles ev_valid=0, pending=0.
// - Priority: fot and test fall same cycle, ev_ready=1 -> code 1 first, then after
//   cooldown code 5; medicina falling during OFFER of fot does not preempt it.
// - Drop/saturation: ev_ready=0, toggle medicina 300 times -> pending[1]=1,
//   drop_count=255, ev_code=2 held stable throughout.
// - Mask: src_mask=5'b00001, test falls -> no pending; pending ult then mask bit3 ->
//   not offered until unmasked, then code 4.
// - Reset mid-operation: pending=5'b10110, OFFER active, pulse reset low 1 cycle ->
//   outputs 0 immediately (async), no event offered after release.

Source files
------------

// File: rtl/event_arbiter.sv
// Queues release events (falling edges) from five debounced sources and grants them one at a
// time, by fixed priority, over a valid/ready handshake followed by a fixed cooldown.
module event_arbiter #(
    parameter int unsigned COOLDOWN = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             test_db_i,
    input  logic             medicina_db_i,
    input  logic             energia_db_i,
    input  logic             ult_db_i,
    input  logic             fot_db_i,
    input  logic [4:0]       src_mask_i,
    input  logic             ev_ready_i,
    output logic             ev_valid_o,
    output logic [2:0]       ev_code_o,
    output logic [4:0]       pending_o,
    output logic [CNT_W-1:0] drop_count_o
);

    localparam int unsigned CdW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    typedef enum logic [1:0] {StIdle, StOffer, StCool} state_e;

    state_e           state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic [CdW-1:0]   cnt_q, cnt_d;
    logic [4:0]       prev_q, pending_q, pending_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [4:0] in_vec, fall, clr, eligible, drops;
    logic [2:0] win_code;
    logic       hs;

    assign in_vec   = {fot_db_i, ult_db_i, energia_db_i, medicina_db_i, test_db_i};
    assign fall     = prev_q & ~in_vec & ~src_mask_i;
    assign eligible = pending_q & ~src_mask_i;
    assign hs       = (state_q == StOffer) && ev_ready_i;
    assign drops    = fall & pending_q & ~clr;

    // Descending scan so the lowest index (highest priority) wins.
    always_comb begin
        win_code = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (eligible[i]) win_code = 3'(i + 1);
        end
    end

    always_comb begin
        clr = 5'b0;
        for (int i = 0; i < 5; i++) begin
            clr[i] = hs && (code_q == 3'(i + 1));
        end
    end

    always_comb begin
        pending_d = (pending_q & ~clr) | fall;
        drop_d    = drop_q;
        for (int i = 0; i < 5; i++) begin
            if (drops[i] && (drop_d != {CNT_W{1'b1}})) drop_d = drop_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q    <= 5'b0;
            pending_q <= 5'b0;
            drop_q    <= '0;
        end else begin
            prev_q    <= in_vec;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            code_q  <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    // The offered code is frozen for the whole OFFER state; no re-arbitration.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (eligible != 5'b0) begin
                    state_d = StOffer;
                    code_d  = win_code;
                end
            end
            StOffer: begin
                if (ev_ready_i) begin
                    code_d = 3'd0;
                    if (COOLDOWN != 0) begin
                        state_d = StCool;
                        cnt_d   = CdW'(COOLDOWN - 1);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StCool: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - CdW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ev_valid_o = (state_q == StOffer);
        ev_code_o  = ev_valid_o ? code_q : 3'd0;
    end

    assign pending_o    = pending_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_event_arbiter.sv
// Directed bench for event_arbiter: reset, latency, cooldown, priority, drop saturation,
// masking and asynchronous reset during an offer.
module tb_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       test_db, medicina_db, energia_db, ult_db, fot_db;
    logic [4:0] src_mask;
    logic       ev_ready;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic [4:0] pending;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

    event_arbiter #(.COOLDOWN(16), .CNT_W(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .test_db_i    (test_db),
        .medicina_db_i(medicina_db),
        .energia_db_i (energia_db),
        .ult_db_i     (ult_db),
        .fot_db_i     (fot_db),
        .src_mask_i   (src_mask),
        .ev_ready_i   (ev_ready),
        .ev_valid_o   (ev_valid),
        .ev_code_o    (ev_code),
        .pending_o    (pending),
        .drop_count_o (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] c);
        chk({tag, "_valid"}, 32'(ev_valid), 32'(v));
        chk({tag, "_code"}, 32'(ev_code), 32'(c));
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            chk_out("cooldown", 1'b0, 3'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {fot_db, ult_db, energia_db, medicina_db, test_db} = 5'b11111;
        src_mask = 5'b0;
        ev_ready = 1'b0;

        // Reset with inputs high.
        repeat (3) tick();
        chk_out("reset", 1'b0, 3'd0);
        chk("reset_pending", 32'(pending), 0);
        chk("reset_drop", 32'(drop_count), 0);

        // Inputs already low at release never yield a fall.
        {fot_db, ult_db, energia_db, medicina_db, test_db} = 5'b00000;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("low_after_reset_pending", 32'(pending), 0);
        chk_out("low_after_reset", 1'b0, 3'd0);
        {fot_db, ult_db, energia_db, medicina_db, test_db} = 5'b11111;
        repeat (2) tick();
        chk("rise_pending", 32'(pending), 0);

        // Single event: energia, 2-cycle latency, then 16-cycle cooldown.
        ev_ready = 1'b1;
        energia_db = 1'b0;
        tick();
        chk("single_pending", 32'(pending), 32'b00100);
        chk_out("single_lat1", 1'b0, 3'd0);
        tick();
        chk_out("single_offer", 1'b1, 3'd3);
        energia_db = 1'b1;
        tick();
        chk_out("single_hs", 1'b0, 3'd0);
        chk("single_cleared", 32'(pending), 0);
        gap(16);

        // Priority: test and fot together.
        test_db = 1'b0;
        fot_db  = 1'b0;
        tick();
        chk("prio_pending", 32'(pending), 32'b10001);
        tick();
        chk_out("prio_first", 1'b1, 3'd1);
        test_db = 1'b1;
        tick();
        chk("prio_after_first", 32'(pending), 32'b10000);
        ev_ready = 1'b0;
        gap(16);
        tick();
        chk_out("prio_second", 1'b1, 3'd5);
        // medicina arriving during the fot offer must not preempt it.
        medicina_db = 1'b0;
        tick();
        chk("preempt_pending", 32'(pending), 32'b10010);
        chk_out("no_preempt1", 1'b1, 3'd5);
        medicina_db = 1'b1;
        tick();
        chk_out("no_preempt2", 1'b1, 3'd5);
        ev_ready = 1'b1;
        fot_db = 1'b1;
        tick();
        chk_out("fot_hs", 1'b0, 3'd0);
        chk("fot_cleared", 32'(pending), 32'b00010);
        gap(16);
        tick();
        chk_out("medicina_offer", 1'b1, 3'd2);
        tick();
        chk("medicina_cleared", 32'(pending), 0);
        ev_ready = 1'b0;
        gap(16);

        // Drop counting and saturation: 300 falls on medicina, 299 dropped.
        for (int i = 0; i < 300; i++) begin
            medicina_db = 1'b0;
            tick();
            medicina_db = 1'b1;
            tick();
            chk("drop_count", 32'(drop_count), (i < 255) ? i : 255);
            chk_out("drop_offer", 1'b1, 3'd2);
        end
        chk("drop_pending", 32'(pending), 32'b00010);
        chk("drop_sat", 32'(drop_count), 255);
        ev_ready = 1'b1;
        tick();
        chk("drop_hs_pending", 32'(pending), 0);
        gap(16);

        // Masked source never latches.
        src_mask = 5'b00001;
        test_db  = 1'b0;
        repeat (2) tick();
        chk("mask_pending", 32'(pending), 0);
        chk_out("mask_no_offer", 1'b0, 3'd0);
        test_db  = 1'b1;
        src_mask = 5'b00000;
        tick();
        // Pending ult masked before it can be offered.
        ev_ready = 1'b0;
        ult_db = 1'b0;
        tick();
        chk("ult_pending", 32'(pending), 32'b01000);
        src_mask = 5'b01000;
        ult_db = 1'b1;
        repeat (4) tick();
        chk_out("ult_masked", 1'b0, 3'd0);
        chk("ult_still_pending", 32'(pending), 32'b01000);
        src_mask = 5'b00000;
        tick();
        chk_out("ult_unmasked", 1'b1, 3'd4);
        ev_ready = 1'b1;
        tick();
        chk("ult_cleared", 32'(pending), 0);
        ev_ready = 1'b0;
        gap(16);

        // Reset asserted during an offer.
        {fot_db, energia_db, medicina_db} = 3'b000;
        tick();
        chk("mid_pending", 32'(pending), 32'b10110);
        tick();
        chk_out("mid_offer", 1'b1, 3'd2);
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 3'd0);
        chk("async_pending", 32'(pending), 0);
        chk("async_drop", 32'(drop_count), 0);
        #3;
        rst_n = 1'b1;
        ev_ready = 1'b1;
        repeat (4) tick();
        chk_out("post_reset", 1'b0, 3'd0);
        chk("post_reset_pending", 32'(pending), 0);
        {fot_db, energia_db, medicina_db} = 3'b111;
        repeat (3) tick();
        chk("post_reset_rise", 32'(pending), 0);
        chk_out("post_reset_idle", 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
